// File: rtl/ecc_pmul_operand_regbank.sv
// Host byte-bus register bank: input operand / result memories, start/busy/done sequencing, cycle counter.
// Latency: host writes land at the next edge; core word reads are registered (1 cycle); host reads are combinational.
// Backpressure: none; host writes to inputs/CTRL while busy are dropped and flagged as overrun.
module ecc_pmul_operand_regbank #(
    parameter int pADDR_WIDTH   = 13,
    parameter int pBYTECNT_SIZE = 8,
    parameter int pWORD_W       = 32,
    parameter int pNUM_WORDS    = 8,
    parameter int pNUM_IN       = 3,
    parameter int pNUM_OUT      = 2,
    localparam int AW           = $clog2(pNUM_WORDS)
) (
    input  logic                          clk,
    input  logic                          reset_i,
    input  logic [pADDR_WIDTH-1:0]        reg_address,
    input  logic [pBYTECNT_SIZE-1:0]      reg_bytecnt,
    input  logic [7:0]                    write_data,
    output logic [7:0]                    read_data,
    input  logic                          reg_read,
    input  logic                          reg_write,
    input  logic                          reg_addrvalid,
    input  logic [pNUM_IN*AW-1:0]         in_addr,
    output logic [pNUM_IN*pWORD_W-1:0]    in_word,
    input  logic [pNUM_OUT*AW-1:0]        out_addr,
    input  logic [pNUM_OUT-1:0]           out_wren,
    input  logic [pNUM_OUT*pWORD_W-1:0]   out_word,
    input  logic                          core_rdy,
    output logic                          start_o,
    output logic                          trigger_o
);

    localparam int WB = pWORD_W / 8;
    localparam int LW = (WB > 1) ? $clog2(WB) : 1;
    localparam int NB = pNUM_WORDS * WB;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ARM,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t state;

    logic [pWORD_W-1:0] in_mem    [pNUM_IN][pNUM_WORDS];
    logic [pWORD_W-1:0] out_mem   [pNUM_OUT][pNUM_WORDS];
    logic [pWORD_W-1:0] in_word_q [pNUM_IN];

    logic        msb_first;
    logic        done;
    logic        overrun;
    logic [31:0] cycles_q;

    logic                     busy;
    logic                     host_wr;
    logic [pNUM_IN-1:0]       in_hit;
    logic [pNUM_OUT-1:0]      out_hit;
    logic                     ctrl_hit;
    logic                     status_hit;
    logic                     cycles_hit;
    logic                     in_range;
    logic [pBYTECNT_SIZE-1:0] byte_idx;
    logic [AW-1:0]            byte_word;
    logic [LW-1:0]            byte_lane;
    logic                     overrun_set;

    assign busy    = (state != ST_IDLE);
    assign host_wr = reg_write && reg_addrvalid;

    // Register decode and host byte -> (word, lane) mapping, honouring MSB_FIRST
    always_comb begin
        for (int i = 0; i < pNUM_IN; i++) begin
            in_hit[i] = (reg_address == pADDR_WIDTH'(i));
        end
        for (int j = 0; j < pNUM_OUT; j++) begin
            out_hit[j] = (reg_address == pADDR_WIDTH'(16 + j));
        end
        ctrl_hit   = (reg_address == pADDR_WIDTH'(32));
        status_hit = (reg_address == pADDR_WIDTH'(33));
        cycles_hit = (reg_address == pADDR_WIDTH'(34));
        in_range   = (int'(reg_bytecnt) < NB);
        byte_idx   = msb_first ? (pBYTECNT_SIZE'(NB - 1) - reg_bytecnt) : reg_bytecnt;
        byte_word  = AW'(byte_idx / pBYTECNT_SIZE'(WB));
        byte_lane  = LW'(byte_idx % pBYTECNT_SIZE'(WB));
        overrun_set = busy && host_wr && ((|in_hit) || ctrl_hit);
    end

    // Host byte writes into input operand memories, locked out while an operation is in flight
    always_ff @(posedge clk) begin
        for (int i = 0; i < pNUM_IN; i++) begin
            if (host_wr && in_hit[i] && !busy && in_range) begin
                for (int l = 0; l < WB; l++) begin
                    if (byte_lane == LW'(l)) begin
                        in_mem[i][byte_word][l*8 +: 8] <= write_data;
                    end
                end
            end
        end
    end

    // Registered core-side operand read; a same-cycle host write is not visible yet
    always_ff @(posedge clk) begin
        if (reset_i) begin
            for (int i = 0; i < pNUM_IN; i++) begin
                in_word_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < pNUM_IN; i++) begin
                in_word_q[i] <= in_mem[i][in_addr[i*AW +: AW]];
            end
        end
    end

    genvar g;
    for (g = 0; g < pNUM_IN; g++) begin : g_in_word
        assign in_word[g*pWORD_W +: pWORD_W] = in_word_q[g];
    end

    // Core result word writes
    always_ff @(posedge clk) begin
        for (int j = 0; j < pNUM_OUT; j++) begin
            if (out_wren[j]) begin
                out_mem[j][out_addr[j*AW +: AW]] <= out_word[j*pWORD_W +: pWORD_W];
            end
        end
    end

    // Operation sequencer with registered start/trigger, status flags and saturating cycle counter
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state     <= ST_IDLE;
            start_o   <= 1'b0;
            trigger_o <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            cycles_q  <= '0;
            msb_first <= 1'b0;
        end else begin
            start_o <= 1'b0;
            if (overrun_set) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (host_wr && ctrl_hit) begin
                        msb_first <= write_data[1];
                        if (write_data[0]) begin
                            state     <= ST_START;
                            start_o   <= 1'b1;
                            trigger_o <= 1'b1;
                            cycles_q  <= '0;
                            done      <= 1'b0;
                            overrun   <= 1'b0;
                        end
                    end
                end
                ST_START: begin
                    state <= ST_ARM;
                end
                ST_ARM: begin
                    state <= ST_RUN;
                    if (cycles_q != '1) cycles_q <= cycles_q + 32'd1;
                end
                ST_RUN: begin
                    if (cycles_q != '1) cycles_q <= cycles_q + 32'd1;
                    if (core_rdy) begin
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        trigger_o <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Host read mux; results are read live even mid-operation
    always_comb begin
        read_data = 8'h00;
        if (reg_read) begin
            for (int i = 0; i < pNUM_IN; i++) begin
                if (in_hit[i] && in_range) begin
                    for (int l = 0; l < WB; l++) begin
                        if (byte_lane == LW'(l)) read_data = in_mem[i][byte_word][l*8 +: 8];
                    end
                end
            end
            for (int j = 0; j < pNUM_OUT; j++) begin
                if (out_hit[j] && in_range) begin
                    for (int l = 0; l < WB; l++) begin
                        if (byte_lane == LW'(l)) read_data = out_mem[j][byte_word][l*8 +: 8];
                    end
                end
            end
            if (ctrl_hit)   read_data = {6'b0, msb_first, 1'b0};
            if (status_hit) read_data = {5'b0, overrun, done, busy};
            if (cycles_hit) begin
                for (int k = 0; k < 4; k++) begin
                    if (reg_bytecnt == pBYTECNT_SIZE'(k)) read_data = cycles_q[k*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ecc_pmul_operand_regbank.sv
// Bench for ecc_pmul_operand_regbank: byte-array reference model, per-cycle compare, directed and random stimulus.
// Latency: model tracks the registered core read (1 cycle) and the combinational host read.
// Backpressure: none; busy-time host writes are expected to be dropped and flagged.
module tb_ecc_pmul_operand_regbank;

    localparam int pADDR_WIDTH   = 13;
    localparam int pBYTECNT_SIZE = 8;
    localparam int pWORD_W       = 32;
    localparam int pNUM_WORDS    = 8;
    localparam int pNUM_IN       = 3;
    localparam int pNUM_OUT      = 2;
    localparam int AW            = 3;
    localparam int WB            = pWORD_W / 8;
    localparam int NB            = pNUM_WORDS * WB;

    logic                          clk;
    logic                          reset_i;
    logic [pADDR_WIDTH-1:0]        reg_address;
    logic [pBYTECNT_SIZE-1:0]      reg_bytecnt;
    logic [7:0]                    write_data;
    logic [7:0]                    read_data;
    logic                          reg_read;
    logic                          reg_write;
    logic                          reg_addrvalid;
    logic [pNUM_IN*AW-1:0]         in_addr;
    logic [pNUM_IN*pWORD_W-1:0]    in_word;
    logic [pNUM_OUT*AW-1:0]        out_addr;
    logic [pNUM_OUT-1:0]           out_wren;
    logic [pNUM_OUT*pWORD_W-1:0]   out_word;
    logic                          core_rdy;
    logic                          start_o;
    logic                          trigger_o;

    ecc_pmul_operand_regbank #(
        .pADDR_WIDTH  (pADDR_WIDTH),
        .pBYTECNT_SIZE(pBYTECNT_SIZE),
        .pWORD_W      (pWORD_W),
        .pNUM_WORDS   (pNUM_WORDS),
        .pNUM_IN      (pNUM_IN),
        .pNUM_OUT     (pNUM_OUT)
    ) dut (
        .clk          (clk),
        .reset_i      (reset_i),
        .reg_address  (reg_address),
        .reg_bytecnt  (reg_bytecnt),
        .write_data   (write_data),
        .read_data    (read_data),
        .reg_read     (reg_read),
        .reg_write    (reg_write),
        .reg_addrvalid(reg_addrvalid),
        .in_addr      (in_addr),
        .in_word      (in_word),
        .out_addr     (out_addr),
        .out_wren     (out_wren),
        .out_word     (out_word),
        .core_rdy     (core_rdy),
        .start_o      (start_o),
        .trigger_o    (trigger_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_start  = 0;
    bit chk_on   = 0;

    // Reference model: operands as flat byte arrays; the operation as "in flight for m_age cycles"
    logic [7:0]         in_bytes  [pNUM_IN][NB];
    logic [7:0]         out_bytes [pNUM_OUT][NB];
    logic [pWORD_W-1:0] m_in_word [pNUM_IN];
    bit                 m_active, m_ending, m_done, m_overrun, m_msb;
    int                 m_age;
    logic [31:0]        m_cycles = 32'd0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [pWORD_W-1:0] in_word_model(input int i, input int w);
        logic [pWORD_W-1:0] r;
        for (int l = 0; l < WB; l++) r[l*8 +: 8] = in_bytes[i][w*WB + l];
        return r;
    endfunction

    function automatic logic [7:0] read_model();
        int a, b, bb;
        a  = int'(reg_address);
        b  = int'(reg_bytecnt);
        bb = m_msb ? (NB - 1 - b) : b;
        if (!reg_read) return 8'h00;
        if (a < pNUM_IN) return (b < NB) ? in_bytes[a][bb] : 8'h00;
        if (a >= 16 && a < 16 + pNUM_OUT) return (b < NB) ? out_bytes[a-16][bb] : 8'h00;
        if (a == 32) return {6'b0, m_msb, 1'b0};
        if (a == 33) return {5'b0, m_overrun, m_done, (m_active || m_ending)};
        if (a == 34) return (b < 4) ? m_cycles[b*8 +: 8] : 8'h00;
        return 8'h00;
    endfunction

    // Model advance on each rising edge, from the inputs held during the cycle
    always @(posedge clk) begin
        bit busy;
        int a, b;
        for (int j = 0; j < pNUM_OUT; j++) begin
            if (out_wren[j]) begin
                a = int'(out_addr[j*AW +: AW]);
                for (int l = 0; l < WB; l++) out_bytes[j][a*WB + l] = out_word[j*pWORD_W + l*8 +: 8];
            end
        end
        if (reset_i) begin
            m_active = 0; m_ending = 0; m_done = 0; m_overrun = 0; m_msb = 0;
            m_cycles = 32'd0;
            for (int i = 0; i < pNUM_IN; i++) m_in_word[i] = '0;
        end else begin
            busy = m_active || m_ending;
            for (int i = 0; i < pNUM_IN; i++) m_in_word[i] = in_word_model(i, int'(in_addr[i*AW +: AW]));
            if (m_ending) begin
                m_ending = 0;
            end else if (m_active) begin
                if (m_age >= 1 && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 32'd1;
                if (m_age >= 2 && core_rdy) begin
                    m_active = 0; m_ending = 1; m_done = 1;
                end
                m_age++;
            end
            if (reg_write && reg_addrvalid) begin
                a = int'(reg_address);
                b = int'(reg_bytecnt);
                if (a < pNUM_IN) begin
                    if (busy) m_overrun = 1;
                    else if (b < NB) in_bytes[a][m_msb ? (NB - 1 - b) : b] = write_data;
                end else if (a == 32) begin
                    if (busy) m_overrun = 1;
                    else begin
                        m_msb = write_data[1];
                        if (write_data[0]) begin
                            m_active = 1; m_age = 0; m_cycles = 32'd0; m_done = 0; m_overrun = 0;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle compare of every DUT output against the model
    always @(negedge clk) begin
        if (start_o === 1'b1) n_start++;
        if (chk_on) begin
            check("start_o", start_o, m_active && m_age == 0);
            check("trigger_o", trigger_o, m_active);
            for (int i = 0; i < pNUM_IN; i++) check("in_word", in_word[i*pWORD_W +: pWORD_W], m_in_word[i]);
            check("read_data", read_data, read_model());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input int a, input int b, input logic [7:0] d);
        reg_address = pADDR_WIDTH'(a); reg_bytecnt = pBYTECNT_SIZE'(b); write_data = d;
        reg_write = 1'b1; reg_addrvalid = 1'b1;
        tick();
        reg_write = 1'b0; reg_addrvalid = 1'b0;
    endtask

    task automatic host_rd(input int a, input int b, output logic [7:0] d);
        reg_address = pADDR_WIDTH'(a); reg_bytecnt = pBYTECNT_SIZE'(b);
        reg_read = 1'b1; reg_addrvalid = 1'b1;
        @(negedge clk);
        d = read_data;
        tick();
        reg_read = 1'b0; reg_addrvalid = 1'b0;
    endtask

    logic [pADDR_WIDTH-1:0] addr_tab [11];

    initial begin
        logic [7:0]  d;
        logic [31:0] cyc;
        int          trig, st, s0, k;
        bit          fin;

        reset_i = 1'b1; reg_address = '0; reg_bytecnt = '0; write_data = '0;
        reg_read = 1'b0; reg_write = 1'b0; reg_addrvalid = 1'b0;
        in_addr = '0; out_addr = '0; out_wren = '0; out_word = '0; core_rdy = 1'b1;
        addr_tab = '{13'h00, 13'h01, 13'h02, 13'h03, 13'h10, 13'h11, 13'h12, 13'h20, 13'h21, 13'h22, 13'h30};

        repeat (3) tick();
        reset_i = 1'b0;
        @(negedge clk);
        check("rst_start", start_o, 1'b0);
        check("rst_trigger", trigger_o, 1'b0);
        check("rst_in_word", in_word, '0);
        tick();
        host_rd(33, 0, d); check("rst_status", d, 8'h00);
        host_rd(32, 0, d); check("rst_ctrl", d, 8'h00);
        host_rd(34, 0, d); check("rst_cycles0", d, 8'h00);

        // Fill every memory so the model knows all contents
        for (int i = 0; i < pNUM_IN; i++)
            for (int b = 0; b < NB; b++) host_wr(i, b, 8'($urandom));
        for (int w = 0; w < pNUM_WORDS; w++) begin
            out_wren = '1;
            for (int j = 0; j < pNUM_OUT; j++) begin
                out_addr[j*AW +: AW] = w[AW-1:0];
                out_word[j*pWORD_W +: pWORD_W] = pWORD_W'($urandom);
            end
            tick();
        end
        out_wren = '0;
        tick();
        chk_on = 1;

        // LSB-first operand load and core read
        for (int b = 0; b < 32; b++) host_wr(0, b, 8'(b));
        in_addr[0 +: AW] = 3'd0;
        tick();
        @(negedge clk); check("t1_word0", in_word[31:0], 32'h0302_0100);
        tick();
        in_addr[0 +: AW] = 3'd7;
        tick();
        @(negedge clk); check("t1_word7", in_word[31:0], 32'h1F1E_1D1C);
        tick();

        // MSB-first byte placement
        host_wr(32, 0, 8'h02);
        host_wr(1, 0, 8'hAA);
        in_addr[AW +: AW] = 3'd7;
        tick();
        @(negedge clk); check("t2_lane", in_word[pWORD_W + 24 +: 8], 8'hAA);
        tick();
        host_rd(1, 0, d);  check("t2_readback", d, 8'hAA);
        host_rd(32, 0, d); check("t2_ctrl", d, 8'h02);
        host_wr(32, 0, 8'h00);

        // Full operation with core_rdy held low
        core_rdy = 1'b0;
        s0 = n_start;
        host_wr(32, 0, 8'h01);
        trig = 0; fin = 0; k = 0;
        while (!fin && k < 300) begin
            @(negedge clk);
            if (trigger_o) trig++;
            if (!trigger_o && trig > 0) fin = 1;
            tick();
            if (trig == 101) core_rdy = 1'b1;
            k++;
        end
        check("t3_completed", fin, 1'b1);
        check("t3_trigger_len", trig, 102);
        check("t3_start_pulses", n_start - s0, 1);
        for (int b = 0; b < 4; b++) begin
            host_rd(34, b, d);
            cyc[b*8 +: 8] = d;
        end
        check("t3_cycles", cyc, 32'd101);
        host_rd(33, 0, d); check("t3_status", d, 8'h02);

        // GO and operand write while busy
        core_rdy = 1'b0;
        s0 = n_start;
        host_wr(32, 0, 8'h01);
        repeat (3) tick();
        host_wr(0, 5, 8'h77);
        host_wr(32, 0, 8'h01);
        host_rd(33, 0, d); check("t4_status_busy", d, 8'h05);
        core_rdy = 1'b1;
        repeat (4) tick();
        check("t4_start_pulses", n_start - s0, 1);
        host_rd(0, 5, d);  check("t4_op0_kept", d, 8'h05);
        host_rd(33, 0, d); check("t4_status_end", d, 8'h06);

        // Reset in the middle of RUN
        core_rdy = 1'b0;
        host_wr(32, 0, 8'h01);
        repeat (10) tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        reg_address = 13'h21; reg_bytecnt = '0; reg_read = 1'b1; reg_addrvalid = 1'b1;
        @(negedge clk);
        check("t5_status", read_data, 8'h00);
        check("t5_trigger", trigger_o, 1'b0);
        tick();
        reg_read = 1'b0; reg_addrvalid = 1'b0;
        core_rdy = 1'b1;
        host_rd(0, 31, d); check("t5_op0_kept", d, 8'h1F);
        host_rd(34, 0, d); check("t5_cycles", d, 8'h00);

        // Result write and host readback
        out_wren = 2'b10;
        out_addr[AW +: AW] = 3'd2;
        out_word[pWORD_W +: pWORD_W] = 32'hDEAD_BEEF;
        tick();
        out_wren = '0;
        host_rd(17, 8, d);  check("t6_b8", d, 8'hEF);
        host_rd(17, 9, d);  check("t6_b9", d, 8'hBE);
        host_rd(17, 10, d); check("t6_b10", d, 8'hAD);
        host_rd(17, 11, d); check("t6_b11", d, 8'hDE);
        host_rd(17, 40, d); check("t6_b40", d, 8'h00);

        // Randomised traffic against the model
        for (int c = 0; c < 4000; c++) begin
            reset_i       = ($urandom_range(0, 399) == 0);
            reg_write     = !reset_i && ($urandom_range(0, 3) == 0);
            reg_addrvalid = ($urandom_range(0, 7) != 0);
            reg_read      = 1'($urandom_range(0, 1));
            reg_address   = addr_tab[$urandom_range(0, 10)];
            reg_bytecnt   = pBYTECNT_SIZE'($urandom_range(0, 40));
            write_data    = 8'($urandom);
            core_rdy      = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < pNUM_IN; i++) in_addr[i*AW +: AW] = AW'($urandom);
            for (int j = 0; j < pNUM_OUT; j++) begin
                out_addr[j*AW +: AW] = AW'($urandom);
                out_word[j*pWORD_W +: pWORD_W] = pWORD_W'($urandom);
            end
            out_wren = pNUM_OUT'($urandom);
            tick();
        end
        reset_i = 1'b0; reg_write = 1'b0; reg_read = 1'b0; out_wren = '0;
        tick();
        chk_on = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
